// File: rtl/seg_scan.sv
// Time-multiplexed scanner for a multi-digit BCD display: blanking between digit slots,
// leading-zero suppression, per-digit blink, and inputs captured once per frame.
module seg_scan #(
    parameter int NUM_DIGITS   = 6,
    parameter int DIV          = 1000,
    parameter int BLANK_CYC    = 50,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic [4*NUM_DIGITS-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0]   DOTS,
    input  logic [NUM_DIGITS-1:0]   BLINK,
    input  logic                    LZ_EN,
    output logic [3:0]              BCD,
    output logic                    DOT,
    output logic [NUM_DIGITS-1:0]   DIGIT_SEL,
    output logic                    FRAME
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic                    ph_q, ph_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dots_q, dots_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    dot_q, dot_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    frame_q, frame_d;
    logic                    all_zero;

    // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        ph_d     = ph_q;
        digits_d = digits_q;
        dots_d   = dots_q;
        blink_d  = blink_q;

        if (!EN) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            bcnt_d  = '0;
            ph_d    = 1'b1;
        end else if (state_q == IDLE) begin
            state_d  = BLANK;
            cnt_d    = '0;
            idx_d    = '0;
            digits_d = DIGITS;
            dots_d   = DOTS;
            blink_d  = BLINK;
        end else if (cnt_q == CW'(DIV - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
                idx_d    = '0;
                digits_d = DIGITS;
                dots_d   = DOTS;
                blink_d  = BLINK;
                if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                    bcnt_d = '0;
                    ph_d   = ~ph_q;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == BLANK && cnt_q == CW'(BLANK_CYC - 1)) begin
                state_d = SHOW;
            end
        end
    end

    // Outputs are derived from the next-state values so the registered outputs match the state after each edge.
    always_comb begin
        bcd_d    = 4'hF;
        dot_d    = 1'b0;
        sel_d    = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (digits_d[4*i +: 4] == 4'd0);
            if (state_d == SHOW && idx_d == IW'(i) && !(blink_d[i] && !ph_d)) begin
                sel_d[i] = 1'b1;
                dot_d    = dots_d[i];
                bcd_d    = (LZ_EN && i != 0 && all_zero) ? 4'hF : digits_d[4*i +: 4];
            end
        end
        frame_d = (state_d != IDLE) && (cnt_d == CW'(DIV - 1)) && (idx_d == IW'(NUM_DIGITS - 1));
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            ph_q    <= 1'b1;
            bcd_q   <= 4'hF;
            dot_q   <= 1'b0;
            sel_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            ph_q    <= ph_d;
            bcd_q   <= bcd_d;
            dot_q   <= dot_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
        end
    end

    // NOTE: the snapshot is data, not control; it is always loaded on leaving IDLE before use, so it needs no reset.
    always_ff @(posedge CLK) begin
        digits_q <= digits_d;
        dots_q   <= dots_d;
        blink_q  <= blink_d;
    end

    assign BCD       = bcd_q;
    assign DOT       = dot_q;
    assign DIGIT_SEL = sel_q;
    assign FRAME     = frame_q;

endmodule
